// File: rtl/hazard_light_seq.sv
// rtl/hazard_light_seq.sv - N-lamp hazard-light sequencer with prescaled calm/scan/flash patterns
module hazard_light_seq #(
    parameter int N_LEDS    = 3,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] rate,
    input  logic                 hold,
    output logic [N_LEDS-1:0]    leds,
    output logic                 step
);

    typedef enum logic [1:0] {
        CALM      = 2'b00,
        SCAN_UP   = 2'b01,
        SCAN_DOWN = 2'b10,
        FLASH     = 2'b11
    } mode_t;

    function automatic logic [N_LEDS-1:0] even_mask();
        logic [N_LEDS-1:0] v;
        v = '0;
        for (int i = 0; i < N_LEDS; i += 2) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    localparam logic [N_LEDS-1:0] EVEN = even_mask();
    localparam logic [N_LEDS-1:0] ODD  = ~EVEN;
    localparam logic [N_LEDS-1:0] ONE  = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] MSB  = {1'b1, {(N_LEDS-1){1'b0}}};
    localparam logic [N_LEDS-1:0] ALL  = '1;
    localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [N_LEDS-1:0] init_pat(input mode_t m);
        case (m)
            CALM:      return EVEN;
            SCAN_UP:   return ONE;
            SCAN_DOWN: return MSB;
            default:   return ALL;
        endcase
    endfunction

    logic [DIV_WIDTH-1:0] cnt;
    mode_t                mode_q;
    mode_t                mode_in;
    logic [N_LEDS-1:0]    adv_pat;
    logic                 legal;
    logic                 onehot;

    assign mode_in = mode_t'(mode);

    // The >= compare lets a lowered rate fire at once instead of wrapping the counter.
    assign step = reset & ~hold & (cnt >= rate);

    assign onehot = (leds != '0) && ((leds & (leds - ONE)) == '0);

    always_comb begin
        adv_pat = leds;
        legal   = 1'b0;
        case (mode_q)
            CALM: begin
                legal   = (leds == EVEN) || (leds == ODD);
                adv_pat = (leds == EVEN) ? ODD : EVEN;
            end
            SCAN_UP: begin
                legal   = onehot;
                adv_pat = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
            end
            SCAN_DOWN: begin
                legal   = onehot;
                adv_pat = {leds[0], leds[N_LEDS-1:1]};
            end
            default: begin
                legal   = (leds == ALL) || (leds == '0);
                adv_pat = (leds == ALL) ? '0 : ALL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            mode_q <= CALM;
            leds   <= EVEN;
        end else if (step) begin
            cnt <= '0;
            if (mode_in != mode_q) begin
                mode_q <= mode_in;
                leds   <= init_pat(mode_in);
            end else if (!legal) begin
                leds <= init_pat(mode_q);
            end else begin
                leds <= adv_pat;
            end
        end else if (!hold) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_light_seq.sv
// tb/tb_hazard_light_seq.sv - scoreboard bench for hazard_light_seq at N=3 and N=5
module tb_hazard_light_seq;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic [23:0] rate;
    logic        hold;
    logic [2:0]  leds3;
    logic [4:0]  leds5;
    logic        step3;
    logic        step5;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] leds;
        logic        step;
        int          which;
        string       name;
    } exp_t;

    exp_t sb[$];

    hazard_light_seq #(.N_LEDS(3), .DIV_WIDTH(24)) dut3 (
        .clk(clk), .reset(reset), .mode(mode), .rate(rate), .hold(hold),
        .leds(leds3), .step(step3)
    );

    hazard_light_seq #(.N_LEDS(5), .DIV_WIDTH(24)) dut5 (
        .clk(clk), .reset(reset), .mode(mode), .rate(rate), .hold(hold),
        .leds(leds5), .step(step5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got no summary, required completion");
        $fatal(1);
    end

    // Drive one cycle of stimulus, queue its expectation, then retire it:
    // step is sampled before the edge, leds after it.
    task automatic apply(input string name, input logic rs, input logic [1:0] m,
                         input logic [23:0] r, input logic h,
                         input logic [31:0] exp_leds, input logic exp_step,
                         input int which);
        exp_t e;
        logic        got_step;
        logic [31:0] got_leds;
        @(negedge clk);
        reset = rs;
        mode  = m;
        rate  = r;
        hold  = h;
        e.leds  = exp_leds;
        e.step  = exp_step;
        e.which = which;
        e.name  = name;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        got_step = (e.which == 5) ? step5 : step3;
        vectors++;
        if (got_step !== e.step) begin
            miscompares++;
            $display("FAIL %s step: got %b, required %b", e.name, got_step, e.step);
        end
        @(posedge clk);
        #1;
        got_leds = (e.which == 5) ? {27'b0, leds5} : {29'b0, leds3};
        vectors++;
        if (got_leds !== e.leds) begin
            miscompares++;
            $display("FAIL %s leds: got %b, required %b", e.name, got_leds, e.leds);
        end
    endtask

    task automatic do_reset(input int which);
        logic [31:0] ev;
        ev = (which == 5) ? 32'b10101 : 32'b101;
        apply("reset", 1'b0, 2'b00, 24'd0, 1'b0, ev, 1'b0, which);
        apply("reset", 1'b0, 2'b00, 24'd0, 1'b0, ev, 1'b0, which);
    endtask

    task automatic test_reset();
        apply("reset_hold", 1'b0, 2'b11, 24'd0, 1'b1, 32'b101, 1'b0, 3);
        apply("reset_n5", 1'b0, 2'b01, 24'd0, 1'b0, 32'b10101, 1'b0, 5);
        apply("reset_n3", 1'b0, 2'b10, 24'd0, 1'b0, 32'b101, 1'b0, 3);
    endtask

    task automatic test_calm();
        logic [2:0] seq[4] = '{3'b010, 3'b101, 3'b010, 3'b101};
        do_reset(3);
        for (int i = 0; i < 4; i++)
            apply("calm", 1'b1, 2'b00, 24'd0, 1'b0, {29'b0, seq[i]}, 1'b1, 3);
    endtask

    task automatic test_scan();
        logic [2:0] up[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [2:0] dn[4] = '{3'b100, 3'b010, 3'b001, 3'b100};
        do_reset(3);
        for (int i = 0; i < 4; i++)
            apply("scan_up", 1'b1, 2'b01, 24'd0, 1'b0, {29'b0, up[i]}, 1'b1, 3);
        for (int i = 0; i < 4; i++)
            apply("scan_down", 1'b1, 2'b10, 24'd0, 1'b0, {29'b0, dn[i]}, 1'b1, 3);
    endtask

    task automatic test_flash_rate();
        logic [2:0] cur;
        do_reset(3);
        cur = 3'b101;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3; i++)
                apply("flash_wait", 1'b1, 2'b11, 24'd3, 1'b0, {29'b0, cur}, 1'b0, 3);
            cur = (p == 1) ? 3'b000 : 3'b111;
            apply("flash_step", 1'b1, 2'b11, 24'd3, 1'b0, {29'b0, cur}, 1'b1, 3);
        end
    endtask

    task automatic test_rate_hold();
        do_reset(3);
        for (int i = 0; i < 4; i++)
            apply("rate5_count", 1'b1, 2'b00, 24'd5, 1'b0, 32'b101, 1'b0, 3);
        apply("rate_lowered", 1'b1, 2'b00, 24'd2, 1'b0, 32'b010, 1'b1, 3);
        apply("rate2_wait", 1'b1, 2'b00, 24'd2, 1'b0, 32'b010, 1'b0, 3);
        apply("rate2_wait", 1'b1, 2'b00, 24'd2, 1'b0, 32'b010, 1'b0, 3);
        apply("rate2_step", 1'b1, 2'b00, 24'd2, 1'b0, 32'b101, 1'b1, 3);
        apply("rate2_wait", 1'b1, 2'b00, 24'd2, 1'b0, 32'b101, 1'b0, 3);
        for (int i = 0; i < 7; i++)
            apply("hold", 1'b1, 2'b01, 24'd2, 1'b1, 32'b101, 1'b0, 3);
        apply("hold_release", 1'b1, 2'b00, 24'd2, 1'b0, 32'b101, 1'b0, 3);
        apply("hold_resume", 1'b1, 2'b00, 24'd2, 1'b0, 32'b010, 1'b1, 3);
    endtask

    task automatic test_n5();
        logic [4:0] dn[6] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
        do_reset(5);
        apply("n5_calm", 1'b1, 2'b00, 24'd0, 1'b0, 32'b01010, 1'b1, 5);
        apply("n5_calm", 1'b1, 2'b00, 24'd0, 1'b0, 32'b10101, 1'b1, 5);
        for (int i = 0; i < 6; i++)
            apply("n5_scan_down", 1'b1, 2'b10, 24'd0, 1'b0, {27'b0, dn[i]}, 1'b1, 5);
    endtask

    task automatic test_back_to_back();
        do_reset(3);
        apply("mid_scan", 1'b1, 2'b10, 24'd0, 1'b0, 32'b100, 1'b1, 3);
        apply("reset_mid", 1'b0, 2'b01, 24'd0, 1'b0, 32'b101, 1'b0, 3);
        apply("post_reset", 1'b1, 2'b01, 24'd0, 1'b0, 32'b001, 1'b1, 3);
        apply("post_reset", 1'b1, 2'b01, 24'd0, 1'b0, 32'b010, 1'b1, 3);
        do_reset(3);
        apply("glitch_away", 1'b1, 2'b11, 24'd2, 1'b0, 32'b101, 1'b0, 3);
        apply("glitch_back", 1'b1, 2'b00, 24'd2, 1'b0, 32'b101, 1'b0, 3);
        apply("glitch_step", 1'b1, 2'b00, 24'd2, 1'b0, 32'b010, 1'b1, 3);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        mode  = 2'b00;
        rate  = 24'd0;
        hold  = 1'b0;
        test_reset();
        test_calm();
        test_scan();
        test_flash_rate();
        test_rate_hold();
        test_n5();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
